// File: rtl/lcd_bus_pkg.sv
// Shared constants for the 4-bit HD44780-style LCD bus (driver and receiver).
package lcd_bus_pkg;

  localparam int unsigned DDRAM_AW = 7;

  localparam logic [7:0] CMD_CLEAR          = 8'h01;
  localparam logic [7:0] CMD_HOME_MASK      = 8'hFE;
  localparam logic [7:0] CMD_HOME           = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MASK     = 8'hFC;
  localparam logic [7:0] CMD_ENTRY          = 8'h04;
  localparam logic [7:0] CMD_SET_DDRAM_MASK = 8'h80;
  localparam logic [7:0] CMD_SET_DDRAM      = 8'h80;
  localparam logic [3:0] FUNC_4BIT_HI       = 4'b0010;

  typedef enum logic {
    HB_EMPTY,
    HB_HAVE_HI
  } half_state_e;

  function automatic logic cmd_match(input logic [7:0] b, input logic [7:0] mask,
                                     input logic [7:0] val);
    return (b & mask) == val;
  endfunction

endpackage

// File: rtl/lcd_bus_rx_if.sv
// LCD pin bundle: enable strobe, register select and D7..D4.
interface lcd_bus_rx_if;
  logic       en;
  logic       rs;
  logic [3:0] data;

  modport master (output en, output rs, output data);
  modport slave  (input  en, input  rs, input  data);
endinterface

// File: rtl/lcd_bus_sync.sv
// Synchronises the LCD pins and flags each falling edge of en as a registered strobe.
module lcd_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rs,
  input  logic [3:0] data,
  output logic       strobe,
  output logic       rs_s,
  output logic [3:0] data_s
);

  logic [SYNC_STAGES-1:0] r_en_sync;
  logic [SYNC_STAGES-1:0] r_rs_sync;
  logic [3:0]             r_data_sync [SYNC_STAGES];
  logic                   r_en_prev;
  logic                   w_en_s;

  assign w_en_s = r_en_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_sync <= '0;
      r_rs_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
      r_en_prev <= 1'b0;
      strobe    <= 1'b0;
      rs_s      <= 1'b0;
      data_s    <= '0;
    end else begin
      r_en_sync[0]   <= en;
      r_rs_sync[0]   <= rs;
      r_data_sync[0] <= data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_en_sync[i]   <= r_en_sync[i-1];
        r_rs_sync[i]   <= r_rs_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
      r_en_prev <= w_en_s;
      // rs/data are re-registered alongside the strobe so they stay aligned with it
      strobe    <= r_en_prev & ~w_en_s;
      rs_s      <= r_rs_sync[SYNC_STAGES-1];
      data_s    <= r_data_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/lcd_bus_rx.sv
// LCD bus receiver: nibble reassembly, 8->4 bit mode switch, command decode and DDRAM cursor.
module lcd_bus_rx
  import lcd_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned NIBBLE_TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                reset,
  lcd_bus_rx_if.slave         bus,
  output logic                byte_valid,
  output logic [7:0]          byte_out,
  output logic                byte_rs,
  output logic                mode_4bit,
  output logic                wr_valid,
  output logic [DDRAM_AW-1:0] wr_addr,
  output logic [7:0]          wr_char,
  output logic                nibble_err
);

  localparam int unsigned CW = (NIBBLE_TIMEOUT > 1) ? $clog2(NIBBLE_TIMEOUT + 1) : 1;

  logic                w_strobe;
  logic                w_rs_s;
  logic [3:0]          w_data_s;
  half_state_e         r_state;
  half_state_e         w_state_nxt;
  logic [3:0]          r_hi;
  logic                r_hi_rs;
  logic [CW-1:0]       r_cnt;
  logic [DDRAM_AW-1:0] r_addr;
  logic                r_inc;
  logic                w_timeout;
  logic                w_emit;
  logic [7:0]          w_byte;
  logic                w_brs;
  logic                w_err;
  logic                w_load_hi;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .en     (bus.en),
    .rs     (bus.rs),
    .data   (bus.data),
    .strobe (w_strobe),
    .rs_s   (w_rs_s),
    .data_s (w_data_s)
  );

  assign w_timeout = (NIBBLE_TIMEOUT != 0) && (r_cnt == CW'(NIBBLE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= HB_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (mode_4bit) begin
      case (r_state)
        HB_EMPTY:   if (w_strobe) w_state_nxt = HB_HAVE_HI;
        HB_HAVE_HI: begin
          if (w_strobe) begin
            if (w_rs_s == r_hi_rs) w_state_nxt = HB_EMPTY;
          end else if (w_timeout) begin
            w_state_nxt = HB_EMPTY;
          end
        end
        default:    w_state_nxt = HB_EMPTY;
      endcase
    end
  end

  // A strobe coinciding with the timeout is checked first, so it completes the byte.
  always_comb begin
    w_emit    = 1'b0;
    w_byte    = '0;
    w_brs     = 1'b0;
    w_err     = 1'b0;
    w_load_hi = 1'b0;
    if (!mode_4bit) begin
      if (w_strobe) begin
        w_emit = 1'b1;
        w_byte = {w_data_s, 4'h0};
        w_brs  = w_rs_s;
      end
    end else if (r_state == HB_EMPTY) begin
      w_load_hi = w_strobe;
    end else if (w_strobe) begin
      if (w_rs_s == r_hi_rs) begin
        w_emit = 1'b1;
        w_byte = {r_hi, w_data_s};
        w_brs  = r_hi_rs;
      end else begin
        w_err     = 1'b1;
        w_load_hi = 1'b1;
      end
    end else begin
      w_err = w_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi       <= '0;
      r_hi_rs    <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_inc      <= 1'b1;
      byte_valid <= 1'b0;
      byte_out   <= '0;
      byte_rs    <= 1'b0;
      mode_4bit  <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_char    <= '0;
      nibble_err <= 1'b0;
    end else begin
      byte_valid <= w_emit;
      wr_valid   <= w_emit && w_brs;
      nibble_err <= w_err;
      if (w_load_hi) begin
        r_hi    <= w_data_s;
        r_hi_rs <= w_rs_s;
        r_cnt   <= '0;
      end else if (r_state == HB_HAVE_HI && !w_strobe) begin
        r_cnt <= w_timeout ? '0 : r_cnt + 1'b1;
      end
      if (w_emit) begin
        byte_out <= w_byte;
        byte_rs  <= w_brs;
        if (w_brs) begin
          wr_addr <= r_addr;
          wr_char <= w_byte;
          r_addr  <= r_inc ? r_addr + 1'b1 : r_addr - 1'b1;
        end else begin
          if (!mode_4bit && w_byte[7:4] == FUNC_4BIT_HI) mode_4bit <= 1'b1;
          if (cmd_match(w_byte, CMD_SET_DDRAM_MASK, CMD_SET_DDRAM)) begin
            r_addr <= w_byte[DDRAM_AW-1:0];
          end else if (cmd_match(w_byte, CMD_ENTRY_MASK, CMD_ENTRY)) begin
            r_inc <= w_byte[1];
          end else if (cmd_match(w_byte, CMD_HOME_MASK, CMD_HOME)) begin
            r_addr <= '0;
          end else if (w_byte == CMD_CLEAR) begin
            r_addr <= '0;
            r_inc  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Scoreboard bench for lcd_bus_rx: directed LCD bus traffic, monitor compares every output pulse.
module tb_lcd_bus_rx;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 16;

  typedef struct { logic [7:0] b; logic rs; logic m; } exp_byte_t;
  typedef struct { logic [6:0] a; logic [7:0] c; } exp_wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_valid, byte_rs, mode_4bit, wr_valid, nibble_err;
  logic [7:0] byte_out, wr_char;
  logic [6:0] wr_addr;

  int        total = 0;
  int        bad = 0;
  int        cyc = 0;
  int        t_fall = 0;
  int        err_pending = 0;
  exp_byte_t q_byte[$];
  exp_wr_t   q_wr[$];

  lcd_bus_rx_if bus ();

  lcd_bus_rx #(.SYNC_STAGES(SYNC_STAGES), .NIBBLE_TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .byte_rs    (byte_rs),
    .mode_4bit  (mode_4bit),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .nibble_err (nibble_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (byte_valid) begin
      total++;
      if (q_byte.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte: got %h rs=%0d, want none", byte_out, byte_rs);
      end else begin
        exp_byte_t e;
        e = q_byte.pop_front();
        if (byte_out !== e.b || byte_rs !== e.rs || mode_4bit !== e.m) begin
          bad++;
          $display("FAIL byte: got %h rs=%0d mode=%0d, want %h rs=%0d mode=%0d",
                   byte_out, byte_rs, mode_4bit, e.b, e.rs, e.m);
        end
      end
      total++;
      if (cyc - t_fall != int'(SYNC_STAGES) + 2) begin
        bad++;
        $display("FAIL latency: got %0d edges, want %0d", cyc - t_fall, SYNC_STAGES + 2);
      end
    end
    if (wr_valid) begin
      total++;
      if (q_wr.size() == 0) begin
        bad++;
        $display("FAIL unexpected_wr: got addr %h char %h, want none", wr_addr, wr_char);
      end else begin
        exp_wr_t w;
        w = q_wr.pop_front();
        if (wr_addr !== w.a || wr_char !== w.c || byte_valid !== 1'b1) begin
          bad++;
          $display("FAIL wr: got addr %h char %h bv=%0d, want addr %h char %h bv=1",
                   wr_addr, wr_char, byte_valid, w.a, w.c);
        end
      end
    end
    if (nibble_err) begin
      total++;
      if (err_pending == 0) begin
        bad++;
        $display("FAIL unexpected_err: got nibble_err=1, want 0");
      end else begin
        err_pending--;
      end
    end
  end

  task automatic nib(input logic r, input logic [3:0] d);
    @(posedge clk); #1;
    bus.rs = r; bus.data = d; bus.en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.en = 1'b0;
    t_fall = cyc;
    repeat (4) @(posedge clk);
  endtask

  task automatic send(input logic r, input logic [7:0] b);
    nib(r, b[7:4]);
    nib(r, b[3:0]);
  endtask

  task automatic exp_b(input logic [7:0] b, input logic r, input logic m);
    exp_byte_t e;
    e.b = b; e.rs = r; e.m = m;
    q_byte.push_back(e);
  endtask

  task automatic exp_w(input logic [6:0] a, input logic [7:0] c);
    exp_wr_t w;
    w.a = a; w.c = c;
    q_wr.push_back(w);
  endtask

  task automatic wr_char_tx(input logic [6:0] a, input logic [7:0] c);
    exp_b(c, 1'b1, 1'b1);
    exp_w(a, c);
    send(1'b1, c);
  endtask

  task automatic cmd_tx(input logic [7:0] c);
    exp_b(c, 1'b0, 1'b1);
    send(1'b0, c);
  endtask

  task automatic check_reset_state(input string name);
    total++;
    if ({byte_valid, byte_out, byte_rs, mode_4bit, wr_valid, wr_addr, wr_char, nibble_err} !== '0) begin
      bad++;
      $display("FAIL %s: got bv=%0d byte=%h rs=%0d mode=%0d wv=%0d addr=%h char=%h err=%0d, want all 0",
               name, byte_valid, byte_out, byte_rs, mode_4bit, wr_valid, wr_addr, wr_char, nibble_err);
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.rs = 1'b0; bus.data = 4'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset_state");
    reset = 1'b0;

    // 8-bit init handshake
    exp_b(8'h30, 1'b0, 1'b0); nib(1'b0, 4'h3);
    exp_b(8'h30, 1'b0, 1'b0); nib(1'b0, 4'h3);
    exp_b(8'h30, 1'b0, 1'b0); nib(1'b0, 4'h3);
    exp_b(8'h20, 1'b0, 1'b1); nib(1'b0, 4'h2);

    cmd_tx(8'h28);
    cmd_tx(8'h0C);
    cmd_tx(8'hC0);
    wr_char_tx(7'h40, 8'h41);
    wr_char_tx(7'h41, 8'h42);

    // wrap upward, then decrement through zero
    cmd_tx(8'hFF);
    wr_char_tx(7'h7F, 8'h5A);
    wr_char_tx(7'h00, 8'h5B);
    cmd_tx(8'h04);
    cmd_tx(8'h80);
    wr_char_tx(7'h00, 8'h61);
    wr_char_tx(7'h7F, 8'h62);
    cmd_tx(8'h01);
    wr_char_tx(7'h00, 8'h63);
    wr_char_tx(7'h01, 8'h64);
    cmd_tx(8'h02);
    wr_char_tx(7'h00, 8'h65);

    // function set DL=1 in 4-bit mode keeps 4-bit mode
    cmd_tx(8'h30);

    // lone high nibble times out
    err_pending++;
    nib(1'b0, 4'h4);
    repeat (20) @(posedge clk);
    cmd_tx(8'h41);

    // rs mismatch: second nibble becomes the new high nibble
    err_pending++;
    nib(1'b0, 4'h6);
    nib(1'b1, 4'h4);
    exp_b(8'h48, 1'b1, 1'b1);
    exp_w(7'h01, 8'h48);
    nib(1'b1, 4'h8);

    // reset while holding a high nibble
    nib(1'b0, 4'h5);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("reset_in_have_hi");
    reset = 1'b0;
    exp_b(8'h30, 1'b0, 1'b0); nib(1'b0, 4'h3);
    exp_b(8'hA0, 1'b1, 1'b0); exp_w(7'h00, 8'hA0); nib(1'b1, 4'hA);

    repeat (20) @(posedge clk);
    total++;
    if (q_byte.size() != 0) begin
      bad++;
      $display("FAIL byte_drain: got %0d bytes missing, want 0", q_byte.size());
    end
    total++;
    if (q_wr.size() != 0) begin
      bad++;
      $display("FAIL wr_drain: got %0d writes missing, want 0", q_wr.size());
    end
    total++;
    if (err_pending != 0) begin
      bad++;
      $display("FAIL err_drain: got %0d errors missing, want 0", err_pending);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
